// File: rtl/axi_pkg.sv
// Shared types and AXI4 encodings for the single-outstanding burst master.
package axi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaddr,
        StWdata,
        StWresp,
        StRaddr,
        StRdata,
        StDone
    } state_e;

    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    // AxSIZE encodes bytes per beat as log2.
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// Command/stream side and AXI4 master side of the burst master, bundled in one interface.
interface axi_burst_master_if #(
    parameter int unsigned G_DATAWIDTH = 32,
    parameter int unsigned G_ADDRWIDTH = 10,
    parameter int unsigned G_ID_WIDTH  = 4
) ();

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [G_ADDRWIDTH-1:0]   cmd_addr;
    logic [7:0]               cmd_len;

    logic [G_DATAWIDTH-1:0]   wr_data;
    logic                     wr_valid;
    logic                     wr_ready;

    logic [G_DATAWIDTH-1:0]   rd_data;
    logic                     rd_last;
    logic                     rd_valid;
    logic                     rd_ready;

    logic                     sts_valid;
    logic                     sts_err;

    logic [G_ID_WIDTH-1:0]    m_axi_awid;
    logic [G_ADDRWIDTH-1:0]   m_axi_awaddr;
    logic [7:0]               m_axi_awlen;
    logic [2:0]               m_axi_awsize;
    logic [1:0]               m_axi_awburst;
    logic                     m_axi_awvalid;
    logic                     m_axi_awready;

    logic [G_DATAWIDTH-1:0]   m_axi_wdata;
    logic [G_DATAWIDTH/8-1:0] m_axi_wstrb;
    logic                     m_axi_wlast;
    logic                     m_axi_wvalid;
    logic                     m_axi_wready;

    logic [G_ID_WIDTH-1:0]    m_axi_bid;
    logic [1:0]               m_axi_bresp;
    logic                     m_axi_bvalid;
    logic                     m_axi_bready;

    logic [G_ID_WIDTH-1:0]    m_axi_arid;
    logic [G_ADDRWIDTH-1:0]   m_axi_araddr;
    logic [7:0]               m_axi_arlen;
    logic [2:0]               m_axi_arsize;
    logic [1:0]               m_axi_arburst;
    logic                     m_axi_arvalid;
    logic                     m_axi_arready;

    logic [G_ID_WIDTH-1:0]    m_axi_rid;
    logic [G_DATAWIDTH-1:0]   m_axi_rdata;
    logic [1:0]               m_axi_rresp;
    logic                     m_axi_rlast;
    logic                     m_axi_rvalid;
    logic                     m_axi_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
        output cmd_ready, wr_ready, rd_data, rd_last, rd_valid, sts_valid, sts_err,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
        input  cmd_ready, wr_ready, rd_data, rd_last, rd_valid, sts_valid, sts_err,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );

endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: one command in, one AW/W/B or AR/R transaction out,
// and a one-cycle completion pulse carrying the error flag.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int unsigned G_DATAWIDTH = 32,
    parameter int unsigned G_ADDRWIDTH = 10,
    parameter int unsigned G_ID_WIDTH  = 4,
    parameter int unsigned G_ID        = 0
) (
    input logic                m_aclk,
    input logic                m_areset,
    axi_burst_master_if.master bus
);

    localparam logic [G_ID_WIDTH-1:0] IdVal = G_ID_WIDTH'(G_ID);

    state_e                 state_q, state_d;
    logic [G_ADDRWIDTH-1:0] addr_q, addr_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   awvalid_q, awvalid_d;
    logic                   arvalid_q, arvalid_d;

    logic last_beat, w_hs, r_hs, r_beat_err;

    assign last_beat  = (cnt_q == len_q);
    assign w_hs       = (state_q == StWdata) && bus.wr_valid && bus.m_axi_wready;
    assign r_hs       = (state_q == StRdata) && bus.m_axi_rvalid && bus.rd_ready;
    // A misplaced rlast (missing on the final beat or early) counts as a protocol error.
    assign r_beat_err = (bus.m_axi_rresp != RespOkay) || (bus.m_axi_rid != IdVal) ||
                        (bus.m_axi_rlast != last_beat);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        awvalid_d = awvalid_q;
        arvalid_d = arvalid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    addr_d = bus.cmd_addr;
                    len_d  = bus.cmd_len;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    if (bus.cmd_write) begin
                        awvalid_d = 1'b1;
                        state_d   = StWaddr;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRaddr;
                    end
                end
            end
            StWaddr: begin
                if (bus.m_axi_awready) begin
                    awvalid_d = 1'b0;
                    state_d   = StWdata;
                end
            end
            StWdata: begin
                if (w_hs) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = StWresp;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StWresp: begin
                if (bus.m_axi_bvalid) begin
                    err_d   = (bus.m_axi_bresp != RespOkay) || (bus.m_axi_bid != IdVal);
                    state_d = StDone;
                end
            end
            StRaddr: begin
                if (bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (r_hs) begin
                    err_d = err_q | r_beat_err;
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge m_aclk) begin
        if (m_areset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            arvalid_q <= arvalid_d;
        end
    end

    assign bus.cmd_ready     = (state_q == StIdle);
    assign bus.sts_valid     = (state_q == StDone);
    assign bus.sts_err       = err_q;

    assign bus.m_axi_awid    = IdVal;
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awlen   = len_q;
    assign bus.m_axi_awsize  = axi_size(G_DATAWIDTH);
    assign bus.m_axi_awburst = BurstIncr;
    assign bus.m_axi_awvalid = awvalid_q;

    assign bus.m_axi_wdata   = bus.wr_data;
    assign bus.m_axi_wstrb   = '1;
    assign bus.m_axi_wlast   = last_beat;
    assign bus.m_axi_wvalid  = (state_q == StWdata) && bus.wr_valid;
    assign bus.wr_ready      = (state_q == StWdata) && bus.m_axi_wready;

    assign bus.m_axi_bready  = (state_q == StWresp);

    assign bus.m_axi_arid    = IdVal;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arlen   = len_q;
    assign bus.m_axi_arsize  = axi_size(G_DATAWIDTH);
    assign bus.m_axi_arburst = BurstIncr;
    assign bus.m_axi_arvalid = arvalid_q;

    assign bus.rd_valid      = (state_q == StRdata) && bus.m_axi_rvalid;
    assign bus.m_axi_rready  = (state_q == StRdata) && bus.rd_ready;
    assign bus.rd_data       = bus.m_axi_rdata;
    assign bus.rd_last       = bus.m_axi_rlast;

endmodule

// File: tb/tb_axi_burst_master.sv
// Randomised bench: a behavioural AXI slave memory and a word-array reference model.
module tb_axi_burst_master;
    import axi_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;
    localparam int unsigned IW = 4;
    localparam int unsigned ID = 3;
    localparam int unsigned Words = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_burst_master_if #(.G_DATAWIDTH(DW), .G_ADDRWIDTH(AW), .G_ID_WIDTH(IW)) bus ();

    axi_burst_master #(
        .G_DATAWIDTH(DW),
        .G_ADDRWIDTH(AW),
        .G_ID_WIDTH (IW),
        .G_ID       (ID)
    ) dut (
        .m_aclk  (clk),
        .m_areset(rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] model_mem[Words];
    logic [31:0] slave_mem[Words];
    logic [31:0] pay[$];
    logic [31:0] wq[$];
    logic [31:0] rd_q[$];
    logic        rd_last_q[$];

    int cycles = 0;
    int acc_cycle = -10;
    logic acc_write = 1'b0;
    logic cmd_pend = 1'b0, c_write = 1'b0;
    logic [9:0] c_addr = '0;
    logic [7:0] c_len = '0;
    logic stall_en = 1'b0, inj_bresp = 1'b0, inj_bid = 1'b0, inj_rlast = 1'b0, inj_rresp = 1'b0;
    logic aw_done = 1'b0, b_pend = 1'b0, r_active = 1'b0, r_hold = 1'b0, wr_hold = 1'b0;
    logic aw_pend = 1'b0, ar_pend = 1'b0;
    logic [17:0] aw_prev = '0, ar_prev = '0;
    logic [9:0] a_addr = '0, r_addr = '0;
    logic [7:0] a_len = '0, r_len = '0;
    int w_idx = 0, r_beat = 0, w_beats = 0, sts_cnt = 0;
    logic sts_err_seen = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rnd_ok();
        return !stall_en || ($urandom_range(0, 3) != 0);
    endfunction

    // One clock: drive on the falling edge, sample 2 ns later (before the rising edge).
    task automatic tick();
        logic [7:0] idx;
        @(negedge clk);
        if (rst) begin
            bus.m_axi_awready = 1'b0;
            bus.m_axi_arready = 1'b0;
            bus.m_axi_wready  = 1'b0;
            bus.m_axi_bvalid  = 1'b0;
            bus.m_axi_rvalid  = 1'b0;
            bus.wr_valid      = 1'b0;
            bus.rd_ready      = 1'b0;
            bus.cmd_valid     = 1'b0;
        end else begin
            bus.m_axi_awready = rnd_ok();
            bus.m_axi_arready = rnd_ok();
            bus.m_axi_wready  = rnd_ok();
            bus.m_axi_bvalid  = b_pend;
            bus.m_axi_bresp   = inj_bresp ? RespSlverr : RespOkay;
            bus.m_axi_bid     = inj_bid ? IW'(ID + 1) : IW'(ID);
            if (!r_hold) begin
                if (r_active && rnd_ok()) begin
                    idx = r_addr[9:2] + 8'(r_beat);
                    bus.m_axi_rvalid = 1'b1;
                    bus.m_axi_rdata  = slave_mem[idx];
                    bus.m_axi_rlast  = (r_beat == int'(r_len)) || (inj_rlast && r_beat == 1);
                    bus.m_axi_rresp  = inj_rresp ? RespDecerr : RespOkay;
                    bus.m_axi_rid    = IW'(ID);
                    r_hold = 1'b1;
                end else begin
                    bus.m_axi_rvalid = 1'b0;
                end
            end
            if (!wr_hold) begin
                if (wq.size() > 0 && rnd_ok()) begin
                    bus.wr_valid = 1'b1;
                    bus.wr_data  = wq[0];
                    wr_hold = 1'b1;
                end else begin
                    bus.wr_valid = 1'b0;
                end
            end
            bus.rd_ready  = rnd_ok();
            bus.cmd_valid = cmd_pend;
            bus.cmd_write = c_write;
            bus.cmd_addr  = c_addr;
            bus.cmd_len   = c_len;
        end
        #2;
        cycles++;
        if (!rst) begin
            if (aw_pend) check("aw_stable", {bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen},
                               {1'b1, aw_prev});
            if (ar_pend) check("ar_stable", {bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen},
                               {1'b1, ar_prev});
            aw_pend = bus.m_axi_awvalid && !bus.m_axi_awready;
            aw_prev = {bus.m_axi_awaddr, bus.m_axi_awlen};
            ar_pend = bus.m_axi_arvalid && !bus.m_axi_arready;
            ar_prev = {bus.m_axi_araddr, bus.m_axi_arlen};
            if (cycles == acc_cycle + 1)
                check("cmd_to_valid", acc_write ? bus.m_axi_awvalid : bus.m_axi_arvalid, 1'b1);
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                check("w_after_aw", aw_done, 1'b1);
                check("w_beat", {bus.m_axi_wlast, bus.m_axi_wstrb, bus.m_axi_wdata},
                      {w_idx == int'(a_len), 4'hf, wq[0]});
                idx = a_addr[9:2] + 8'(w_idx);
                slave_mem[idx] = bus.m_axi_wdata;
                w_beats++;
                w_idx++;
                if (w_idx == int'(a_len) + 1) b_pend = 1'b1;
                void'(wq.pop_front());
                wr_hold = 1'b0;
            end
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                check("aw_payload", {bus.m_axi_awid, bus.m_axi_awaddr, bus.m_axi_awlen,
                      bus.m_axi_awsize, bus.m_axi_awburst}, {IW'(ID), c_addr, c_len, 3'd2, 2'b01});
                aw_done = 1'b1;
                a_addr  = bus.m_axi_awaddr;
                a_len   = bus.m_axi_awlen;
                w_idx   = 0;
            end
            if (bus.m_axi_bvalid && bus.m_axi_bready) b_pend = 1'b0;
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                check("ar_payload", {bus.m_axi_arid, bus.m_axi_araddr, bus.m_axi_arlen,
                      bus.m_axi_arsize, bus.m_axi_arburst}, {IW'(ID), c_addr, c_len, 3'd2, 2'b01});
                r_active = 1'b1;
                r_addr   = bus.m_axi_araddr;
                r_len    = bus.m_axi_arlen;
                r_beat   = 0;
            end
            if (bus.m_axi_rvalid && bus.m_axi_rready) begin
                r_hold = 1'b0;
                r_beat++;
                if (r_beat > int'(r_len)) r_active = 1'b0;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                rd_q.push_back(bus.rd_data);
                rd_last_q.push_back(bus.rd_last);
            end
            if (bus.sts_valid) begin
                sts_cnt++;
                sts_err_seen = bus.sts_err;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                cmd_pend  = 1'b0;
                acc_cycle = cycles;
                acc_write = c_write;
                aw_done   = 1'b0;
            end
        end
    endtask

    task automatic run_cmd(input logic exp_err);
        int n;
        cmd_pend = 1'b1;
        sts_cnt  = 0;
        w_beats  = 0;
        rd_q.delete();
        rd_last_q.delete();
        n = 0;
        while (sts_cnt == 0 && n < 4000) begin
            tick();
            n++;
        end
        check("done_in_budget", sts_cnt != 0, 1'b1);
        tick();
        tick();
        check("sts_one_cycle", sts_cnt, 1);
        check("sts_err", sts_err_seen, exp_err);
        check("idle_after", bus.cmd_ready, 1'b1);
    endtask

    task automatic write_burst(input logic [9:0] addr, input logic [7:0] len, input logic exp_err);
        logic [7:0] idx;
        wq = pay;
        for (int i = 0; i <= int'(len); i++) begin
            idx = addr[9:2] + 8'(i);
            model_mem[idx] = pay[i];
        end
        c_write = 1'b1;
        c_addr  = addr;
        c_len   = len;
        run_cmd(exp_err);
        check("w_count", w_beats, int'(len) + 1);
        for (int i = 0; i <= int'(len); i++) begin
            idx = addr[9:2] + 8'(i);
            check("mem_word", slave_mem[idx], model_mem[idx]);
        end
    endtask

    task automatic read_burst(input logic [9:0] addr, input logic [7:0] len, input logic exp_err);
        logic [7:0] idx;
        c_write = 1'b0;
        c_addr  = addr;
        c_len   = len;
        run_cmd(exp_err);
        check("r_count", rd_q.size(), int'(len) + 1);
        for (int i = 0; i < rd_q.size() && i <= int'(len); i++) begin
            idx = addr[9:2] + 8'(i);
            check("rd_data", rd_q[i], model_mem[idx]);
            if (!inj_rlast) check("rd_last", rd_last_q[i], i == int'(len));
        end
    endtask

    task automatic fill_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back($urandom());
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, word, n;
        for (int i = 0; i < int'(Words); i++) begin
            model_mem[i] = '0;
            slave_mem[i] = '0;
        end
        bus.m_axi_awready = 1'b0; bus.m_axi_arready = 1'b0; bus.m_axi_wready = 1'b0;
        bus.m_axi_bvalid = 1'b0;  bus.m_axi_bresp = '0;     bus.m_axi_bid = '0;
        bus.m_axi_rvalid = 1'b0;  bus.m_axi_rdata = '0;     bus.m_axi_rresp = '0;
        bus.m_axi_rlast = 1'b0;   bus.m_axi_rid = '0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_valid = 1'b0;  bus.wr_data = '0;     bus.rd_ready = 1'b0;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_awvalid", bus.m_axi_awvalid, 1'b0);
        check("rst_arvalid", bus.m_axi_arvalid, 1'b0);
        check("rst_bready", bus.m_axi_bready, 1'b0);
        check("rst_sts_valid", bus.sts_valid, 1'b0);

        pay = '{32'h11, 32'h22, 32'h33, 32'h44};
        write_burst(10'h000, 8'd3, 1'b0);
        read_burst(10'h000, 8'd3, 1'b0);

        pay = '{32'hDEADBEEF};
        write_burst(10'h3FC, 8'd0, 1'b0);
        read_burst(10'h3FC, 8'd0, 1'b0);

        stall_en = 1'b1;
        fill_random(256);
        write_burst(10'h000, 8'd255, 1'b0);
        read_burst(10'h000, 8'd255, 1'b0);

        for (int k = 0; k < 4; k++) begin
            len  = $urandom_range(0, 15);
            word = $urandom_range(0, 255 - len);
            fill_random(len + 1);
            write_burst(10'(word * 4), 8'(len), 1'b0);
            read_burst(10'(word * 4), 8'(len), 1'b0);
        end

        fill_random(4);
        inj_bresp = 1'b1;
        write_burst(10'h040, 8'd3, 1'b1);
        inj_bresp = 1'b0;
        inj_bid = 1'b1;
        write_burst(10'h040, 8'd3, 1'b1);
        inj_bid = 1'b0;
        inj_rlast = 1'b1;
        read_burst(10'h040, 8'd3, 1'b1);
        inj_rlast = 1'b0;
        inj_rresp = 1'b1;
        read_burst(10'h040, 8'd3, 1'b1);
        inj_rresp = 1'b0;
        read_burst(10'h040, 8'd3, 1'b0);

        // Abandon a write in the middle of its third data beat.
        stall_en = 1'b0;
        fill_random(4);
        wq = pay;
        c_write = 1'b1; c_addr = 10'h100; c_len = 8'd3;
        cmd_pend = 1'b1;
        sts_cnt = 0;
        n = 0;
        while (!(aw_done && w_idx >= 2) && n < 200) begin
            tick();
            n++;
        end
        check("reached_beat2", aw_done && w_idx >= 2, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b_pend = 1'b0; r_active = 1'b0; r_hold = 1'b0; wr_hold = 1'b0; cmd_pend = 1'b0;
        aw_pend = 1'b0; ar_pend = 1'b0; wq.delete();
        tick();
        check("mid_rst_awvalid", bus.m_axi_awvalid, 1'b0);
        check("mid_rst_sts_valid", bus.sts_valid, 1'b0);
        check("mid_rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("mid_rst_wready", bus.wr_ready, 1'b0);
        repeat (5) tick();
        check("mid_rst_no_sts", sts_cnt, 0);

        fill_random(4);
        write_burst(10'h100, 8'd3, 1'b0);
        read_burst(10'h100, 8'd3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 Parameter G_DATAWIDTH, default 32; AXI data width in bits (32 or 64).
REQ-002 Parameter G_ADDRWIDTH, default 10; AXI byte-address width.
REQ-003 Parameter G_ID_WIDTH, default 4; AXI ID width.
REQ-004 Parameter G_ID, default 0; ID driven on awid/arid.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 m_aclk  in  1  sole clock, all logic on rising edge.
REQ-007 m_areset  in  1  synchronous active-high reset.
REQ-008 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-009 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-010 cmd_addr  in  G_ADDRWIDTH  start byte address, beat-aligned.
REQ-011 cmd_len  in  8  beats minus one (AXI4 LEN encoding).
REQ-012 wr_data/wr_valid/wr_ready  in/in/out  G_DATAWIDTH/1/1  write-data stream.
REQ-013 rd_data/rd_last/rd_valid  out/out/out  G_DATAWIDTH/1/1  read-data stream; rd_ready in 1.
REQ-014 sts_valid/sts_err  out/out  1/1  one-cycle completion pulse; error flag.
REQ-015 m_axi_aw{id,addr,len,size,burst,valid} out; m_axi_awready in.
REQ-016 m_axi_w{data,strb,last,valid} out; m_axi_wready in.
REQ-017 m_axi_b{id,resp,valid} in; m_axi_bready out.
REQ-018 m_axi_ar{id,addr,len,size,burst,valid} out; m_axi_arready in.
REQ-019 m_axi_r{id,data,resp,last,valid} in; m_axi_rready out.

Function
REQ-020 FSM states SHALL be IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.
REQ-021 IDLE: cmd_ready=1; on cmd_valid, SHALL latch addr/len/write and go to WADDR (write) or RADDR (read).
REQ-022 At most one transaction SHALL be outstanding; cmd_ready=0 outside IDLE.
REQ-023 awburst/arburst SHALL be 2'b01 (INCR); awsize/arsize = log2(G_DATAWIDTH/8); awid/arid = G_ID.
REQ-024 awvalid/arvalid SHALL be registered, held with stable payload until ready; no dependence on ready before assertion.
REQ-025 WADDR SHALL go to WDATA after AW handshake; W beats SHALL NOT be issued before AW accepted.
REQ-026 WDATA: m_axi_wvalid=wr_valid, wr_ready=m_axi_wready, wdata=wr_data, wstrb all ones (combinational pass-through).
REQ-027 8-bit beat counter SHALL count W handshakes; wlast=1 iff counter==len; after last handshake go to WRESP.
REQ-028 WRESP: bready=1; on bvalid, sts_err=(bresp!=OKAY) or (bid!=G_ID); go to DONE.
REQ-029 RADDR SHALL go to RDATA after AR handshake.
REQ-030 RDATA: rd_valid=rvalid, rready=rd_ready, rd_data=rdata, rd_last=rlast (pass-through).
REQ-031 Read error SHALL be sticky-OR over beats of (rresp!=OKAY) or (rid!=G_ID).
REQ-032 rlast absent on beat len, or present before it, SHALL set error; state exits on beat len regardless.
REQ-033 DONE SHALL pulse sts_valid for exactly one cycle, then return to IDLE.
REQ-034 len=0 SHALL produce single-beat bursts with wlast on first beat.
REQ-035 Burst crossing 4 KB boundary or address wrap beyond 2^G_ADDRWIDTH is caller's responsibility; no checking.
REQ-036 Command accept to awvalid/arvalid SHALL be 1 cycle.

Reset
REQ-037 On m_areset: state IDLE, counter 0, error 0; awvalid, arvalid, bready, sts_valid =0; cmd_ready=1 from first cycle after reset.
REQ-038 Reset mid-burst SHALL abandon the transaction immediately; no completion pulse.

Structure
REQ-039 Package axi_pkg SHALL hold state enum, burst/resp constants (INCR, OKAY, SLVERR, DECERR).
REQ-040 Single module, no sub-modules; test harness pairs it with axi_1p memory.

Verification
REQ-041 Write addr 0x000, len 3, data 0x11..0x44 -> four beats, wlast on 4th, sts_err=0, memory holds data.
REQ-042 Read addr 0x000, len 3 -> rd_data 0x11,0x22,0x33,0x44, rd_last on 4th, sts_valid one cycle.
REQ-043 len 0 write 0xDEADBEEF to 0x3FC, read back -> single beat, match, no error.
REQ-044 Random rd_ready/wr_valid stalls, len 255 -> 256 beats in order, AW/AR payload stable while valid.
REQ-045 Injected bresp=SLVERR -> sts_err=1; injected early rlast -> sts_err=1.
REQ-046 Reset asserted during WDATA beat 2 -> awvalid/sts_valid low, cmd_ready=1 next cycle.
